vga_embarcacao_decoder: RTL and testbench

Consumer end of the ship-position bus. Latches the packed 64-bit posicoesEmbarcacao vector at frame start and decodes it, one entry per cycle, into a 15x15 occupancy bitmap. The bitmap is double-buffered. For each VGA pixel it answers whether the pixel falls inside an occupied board cell. It sits between the position source (game memory or test stimulus) and the VGA colour mux.

---
 rtl/embarcacao_pkg.sv | 35 +++
 rtl/vga_cell_mapper.sv | 32 +++
 rtl/vga_embarcacao_decoder.sv | 149 ++++++++++++++
 tb/tb_vga_embarcacao_decoder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/embarcacao_pkg.sv
// Shared types and constants for the ship-position decoder.
// Optional build macro EMBARCACAO_OVERLAP_EN is consumed by vga_embarcacao_decoder.
package embarcacao_pkg;

    localparam int unsigned GRID_N    = 15;
    localparam int unsigned N_ENTRIES = 8;
    localparam int unsigned ENTRY_W   = 8;
    localparam int unsigned COORD_W   = 4;
    localparam int unsigned MAP_W     = GRID_N * GRID_N;
    localparam int unsigned BIT_W     = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned COUNT_W   = 4;
    localparam int unsigned VEC_W     = N_ENTRIES * ENTRY_W;
    localparam int unsigned PIX_W     = 10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CLEAR  = 2'd1,
        S_SCAN   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    // Flat bitmap index of 1-based board cell (x, y).
    function automatic logic [BIT_W-1:0] bit_index(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
        return BIT_W'((32'(y) - 32'd1) * GRID_N + (32'(x) - 32'd1));
    endfunction

    // A zero coordinate marks an unused slot.
    function automatic logic coord_valid(input logic [COORD_W-1:0] x,
                                         input logic [COORD_W-1:0] y);
        return (x != '0) && (y != '0);
    endfunction

endpackage

// File: rtl/vga_cell_mapper.sv
// Combinational pixel-to-board-cell mapper: board hit plus 0-based column/row.
module vga_cell_mapper
    import embarcacao_pkg::*;
#(
    parameter int unsigned CELL_LOG2 = 5,
    parameter int unsigned ORIGIN_X  = 80,
    parameter int unsigned ORIGIN_Y  = 0
) (
    input  logic [PIX_W-1:0]   pixel_x,
    input  logic [PIX_W-1:0]   pixel_y,
    output logic               hit,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row
);

    localparam int unsigned EXT_W = PIX_W + 1;
    localparam int unsigned SPAN  = GRID_N << CELL_LOG2;

    logic [EXT_W-1:0] dx;
    logic [EXT_W-1:0] dy;

    // Offsets carry one extra bit so a pixel left of / above the origin shows up as a borrow, not a wrap.
    always_comb begin
        dx  = {1'b0, pixel_x} - EXT_W'(ORIGIN_X);
        dy  = {1'b0, pixel_y} - EXT_W'(ORIGIN_Y);
        hit = !dx[EXT_W-1] && (dx < EXT_W'(SPAN)) &&
              !dy[EXT_W-1] && (dy < EXT_W'(SPAN));
        col = COORD_W'(dx >> CELL_LOG2);
        row = COORD_W'(dy >> CELL_LOG2);
    end

endmodule

// File: rtl/vga_embarcacao_decoder.sv
// Ship-position decoder: latches the 8-entry position vector at frame start, decodes it
// into a double-buffered 15x15 occupancy bitmap, and answers per-pixel occupancy.
// Build macro EMBARCACAO_OVERLAP_EN enables duplicate-cell detection on overlap_err.
module vga_embarcacao_decoder
    import embarcacao_pkg::*;
#(
    parameter int unsigned CELL_LOG2 = 5,
    parameter int unsigned ORIGIN_X  = 80,
    parameter int unsigned ORIGIN_Y  = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_start,
    input  logic [VEC_W-1:0]   posicoesEmbarcacao,
    input  logic [PIX_W-1:0]   pixel_x,
    input  logic [PIX_W-1:0]   pixel_y,
    input  logic               pixel_valid,
    output logic               ship_pixel,
    output logic               map_ready,
    output logic               busy,
    output logic [COUNT_W-1:0] cell_count,
    output logic               overlap_err
);

    state_t               state;
    logic [VEC_W-1:0]     vec;
    logic [IDX_W-1:0]     idx;
    logic [MAP_W-1:0]     shadow;
    logic [MAP_W-1:0]     display;
    logic [COUNT_W-1:0]   shadow_count;

    logic [ENTRY_W-1:0]   entry;
    logic                 entry_valid;
    logic [BIT_W-1:0]     entry_bit;
    logic                 entry_dup;

    logic                 hit;
    logic [COORD_W-1:0]   col;
    logic [COORD_W-1:0]   row;
    logic [BIT_W-1:0]     pix_bit;
    logic                 pix_occ;

    vga_cell_mapper #(
        .CELL_LOG2 (CELL_LOG2),
        .ORIGIN_X  (ORIGIN_X),
        .ORIGIN_Y  (ORIGIN_Y)
    ) u_mapper (
        .pixel_x (pixel_x),
        .pixel_y (pixel_y),
        .hit     (hit),
        .col     (col),
        .row     (row)
    );

    // Current scan entry and pixel lookup; out-of-range indices are always masked by their qualifier.
    always_comb begin
        entry       = vec[32'(idx) * ENTRY_W +: ENTRY_W];
        entry_valid = coord_valid(entry[COORD_W-1:0], entry[ENTRY_W-1:COORD_W]);
        entry_bit   = bit_index(entry[COORD_W-1:0], entry[ENTRY_W-1:COORD_W]);
        entry_dup   = entry_valid && shadow[entry_bit];
        pix_bit     = BIT_W'(32'(row) * GRID_N + 32'(col));
        pix_occ     = hit && display[pix_bit];
    end

    // Decode FSM: latch, clear shadow, scan eight entries, commit to the display buffer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            vec          <= '0;
            idx          <= '0;
            shadow       <= '0;
            shadow_count <= '0;
            display      <= '0;
            cell_count   <= '0;
            map_ready    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            map_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        vec   <= posicoesEmbarcacao;
                        busy  <= 1'b1;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    shadow       <= '0;
                    shadow_count <= '0;
                    idx          <= '0;
                    state        <= S_SCAN;
                end
                S_SCAN: begin
                    if (entry_valid) begin
                        shadow[entry_bit] <= 1'b1;
                        if (!entry_dup) begin
                            shadow_count <= shadow_count + COUNT_W'(1);
                        end
                    end
                    if (idx == IDX_W'(N_ENTRIES - 1)) begin
                        state <= S_COMMIT;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                S_COMMIT: begin
                    display    <= shadow;
                    cell_count <= shadow_count;
                    map_ready  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef EMBARCACAO_OVERLAP_EN
    logic shadow_ovl;

    // Duplicate-cell flag, built alongside the shadow map and published at commit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_ovl  <= 1'b0;
            overlap_err <= 1'b0;
        end else if (state == S_CLEAR) begin
            shadow_ovl <= 1'b0;
        end else if (state == S_SCAN) begin
            if (entry_dup) begin
                shadow_ovl <= 1'b1;
            end
        end else if (state == S_COMMIT) begin
            overlap_err <= shadow_ovl;
        end
    end
`else
    assign overlap_err = 1'b0;
`endif

    // Registered pixel answer, one cycle behind the pixel coordinates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ship_pixel <= 1'b0;
        end else begin
            ship_pixel <= pixel_valid && pix_occ;
        end
    end

endmodule

// File: tb/tb_vga_embarcacao_decoder.sv
// Self-checking bench for vga_embarcacao_decoder with a cell-set reference model.
module tb_vga_embarcacao_decoder;

`ifdef EMBARCACAO_OVERLAP_EN
    localparam bit OVL_EN = 1'b1;
`else
    localparam bit OVL_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [63:0] posicoesEmbarcacao = '0;
    logic [9:0]  pixel_x = '0;
    logic [9:0]  pixel_y = '0;
    logic        pixel_valid = 1'b0;
    logic        ship_pixel;
    logic        map_ready;
    logic        busy;
    logic [3:0]  cell_count;
    logic        overlap_err;

    int errors = 0;
    int checks = 0;

    bit model_occ [1:15][1:15];
    int model_count;
    bit model_ovl;

    vga_embarcacao_decoder dut (
        .clock              (clock),
        .reset              (reset),
        .frame_start        (frame_start),
        .posicoesEmbarcacao (posicoesEmbarcacao),
        .pixel_x            (pixel_x),
        .pixel_y            (pixel_y),
        .pixel_valid        (pixel_valid),
        .ship_pixel         (ship_pixel),
        .map_ready          (map_ready),
        .busy               (busy),
        .cell_count         (cell_count),
        .overlap_err        (overlap_err)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: set of occupied cells, distinct count, duplicate flag.
    task automatic model_load(input logic [63:0] v);
        int x, y;
        for (int i = 1; i <= 15; i++)
            for (int j = 1; j <= 15; j++)
                model_occ[i][j] = 1'b0;
        model_count = 0;
        model_ovl   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            x = int'(v[k*8 +: 4]);
            y = int'(v[k*8+4 +: 4]);
            if (x >= 1 && y >= 1) begin
                if (model_occ[x][y]) model_ovl = 1'b1;
                else begin
                    model_occ[x][y] = 1'b1;
                    model_count++;
                end
            end
        end
    endtask

    function automatic bit ref_pix(input int x, input int y, input bit v);
        if (!v) return 1'b0;
        if (x < 80 || x >= 80 + 15 * 32 || y < 0 || y >= 15 * 32) return 1'b0;
        return model_occ[(x - 80) / 32 + 1][y / 32 + 1];
    endfunction

    // Pulse frame_start and measure edges until map_ready; tail = map_ready one cycle later.
    task automatic do_frame(input logic [63:0] v, output int lat, output bit tail);
        posicoesEmbarcacao = v;
        frame_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        frame_start = 1'b0;
        lat  = -1;
        tail = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (map_ready) begin
                lat = n;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clock);
            @(negedge clock);
            tail = map_ready;
        end
    endtask

    task automatic probe(input int x, input int y, input bit v, output bit got);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        pixel_valid = v;
        @(posedge clock);
        @(negedge clock);
        got = ship_pixel;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++; if (ship_pixel !== 1'b0) begin errors++; $display("FAIL reset_ship_pixel got=%b want=0", ship_pixel); end
        checks++; if (map_ready !== 1'b0) begin errors++; $display("FAIL reset_map_ready got=%b want=0", map_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (cell_count !== 4'd0) begin errors++; $display("FAIL reset_cell_count got=%0d want=0", cell_count); end
        checks++; if (overlap_err !== 1'b0) begin errors++; $display("FAIL reset_overlap got=%b want=0", overlap_err); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single();
        int lat; bit tail; bit got;
        int xs [4] = '{80, 79, 112, 80};
        int ys [4] = '{0, 0, 0, 32};
        bit ex [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        model_load(64'h11);
        do_frame(64'h11, lat, tail);
        checks++; if (lat !== 10) begin errors++; $display("FAIL single_latency got=%0d want=10", lat); end
        checks++; if (tail !== 1'b0) begin errors++; $display("FAIL single_ready_width got=%b want=0", tail); end
        checks++; if (cell_count !== 4'd1) begin errors++; $display("FAIL single_count got=%0d want=1", cell_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b want=0", busy); end
        for (int i = 0; i < 4; i++) begin
            probe(xs[i], ys[i], 1'b1, got);
            checks++; if (got !== ex[i]) begin errors++; $display("FAIL single_pixel(%0d,%0d) got=%b want=%b", xs[i], ys[i], got, ex[i]); end
        end
    endtask

    task automatic test_corner();
        int lat; bit tail; bit got;
        int xs [3] = '{559, 560, 559};
        int ys [3] = '{479, 479, 480};
        bit ex [3] = '{1'b1, 1'b0, 1'b0};
        do_frame(64'h50FF, lat, tail);
        checks++; if (lat !== 10) begin errors++; $display("FAIL corner_latency got=%0d want=10", lat); end
        checks++; if (cell_count !== 4'd1) begin errors++; $display("FAIL corner_count got=%0d want=1", cell_count); end
        for (int i = 0; i < 3; i++) begin
            probe(xs[i], ys[i], 1'b1, got);
            checks++; if (got !== ex[i]) begin errors++; $display("FAIL corner_pixel(%0d,%0d) got=%b want=%b", xs[i], ys[i], got, ex[i]); end
        end
    endtask

    task automatic test_overlap();
        int lat; bit tail;
        do_frame(64'h0000_0000_2400_0024, lat, tail);
        checks++; if (cell_count !== 4'd1) begin errors++; $display("FAIL overlap_count got=%0d want=1", cell_count); end
        checks++; if (overlap_err !== OVL_EN) begin errors++; $display("FAIL overlap_flag got=%b want=%b", overlap_err, OVL_EN); end
        do_frame(64'h0000_0000_3300_0024, lat, tail);
        checks++; if (cell_count !== 4'd2) begin errors++; $display("FAIL overlap_clear_count got=%0d want=2", cell_count); end
        checks++; if (overlap_err !== 1'b0) begin errors++; $display("FAIL overlap_clear_flag got=%b want=0", overlap_err); end
    endtask

    task automatic test_stability();
        int lat; bit tail; bit got; bit ref_a; int ready_cnt;
        logic [63:0] va = 64'h0000_0000_0000_3211;
        logic [63:0] vb = 64'h0000_0000_0000_0077;
        logic [63:0] vc = 64'h3232_3232_3232_3232;
        do_frame(va, lat, tail);
        model_load(va);
        ref_a = ref_pix(117, 69, 1'b1);
        pixel_x = 10'd117; pixel_y = 10'd69; pixel_valid = 1'b1;
        posicoesEmbarcacao = vb;
        frame_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        frame_start = 1'b0;
        ready_cnt = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc == 4) begin frame_start = 1'b1; posicoesEmbarcacao = vc; end
            if (cyc == 6) frame_start = 1'b0;
            @(posedge clock);
            @(negedge clock);
            if (map_ready) ready_cnt++;
            if (cyc <= 10) begin
                checks++; if (ship_pixel !== ref_a) begin errors++; $display("FAIL stable_pixel cyc=%0d got=%b want=%b", cyc, ship_pixel, ref_a); end
            end
        end
        checks++; if (ready_cnt !== 1) begin errors++; $display("FAIL stable_ready_pulses got=%0d want=1", ready_cnt); end
        model_load(vb);
        checks++; if (cell_count !== 4'(model_count)) begin errors++; $display("FAIL stable_count got=%0d want=%0d", cell_count, model_count); end
        probe(117, 69, 1'b1, got);
        checks++; if (got !== ref_pix(117, 69, 1'b1)) begin errors++; $display("FAIL stable_new_pixel got=%b want=%b", got, ref_pix(117, 69, 1'b1)); end
    endtask

    task automatic test_reset_mid();
        int lat; bit tail; bit got; int ready_cnt;
        logic [63:0] va = 64'h0000_0000_0000_3211;
        logic [63:0] vb = 64'h0000_0000_0000_0077;
        do_frame(va, lat, tail);
        pixel_x = 10'd117; pixel_y = 10'd69; pixel_valid = 1'b1;
        posicoesEmbarcacao = vb;
        frame_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        frame_start = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b want=0", busy); end
        checks++; if (ship_pixel !== 1'b0) begin errors++; $display("FAIL midreset_ship_pixel got=%b want=0", ship_pixel); end
        checks++; if (cell_count !== 4'd0) begin errors++; $display("FAIL midreset_count got=%0d want=0", cell_count); end
        checks++; if (overlap_err !== 1'b0 || map_ready !== 1'b0) begin errors++; $display("FAIL midreset_flags got=%b%b want=00", overlap_err, map_ready); end
        @(negedge clock);
        reset = 1'b0;
        ready_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (map_ready) ready_cnt++;
        end
        checks++; if (ready_cnt !== 0) begin errors++; $display("FAIL midreset_no_ready got=%0d want=0", ready_cnt); end
        probe(117, 69, 1'b1, got);
        checks++; if (got !== 1'b0) begin errors++; $display("FAIL midreset_display_cleared got=%b want=0", got); end
        model_load(vb);
        do_frame(vb, lat, tail);
        checks++; if (lat !== 10) begin errors++; $display("FAIL midreset_relatency got=%0d want=10", lat); end
        checks++; if (cell_count !== 4'(model_count)) begin errors++; $display("FAIL midreset_recount got=%0d want=%0d", cell_count, model_count); end
    endtask

    task automatic test_pixel_valid();
        bit got;
        probe(282, 202, 1'b0, got);
        checks++; if (got !== 1'b0) begin errors++; $display("FAIL pixel_invalid got=%b want=0", got); end
        probe(282, 202, 1'b1, got);
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL pixel_valid got=%b want=1", got); end
    endtask

    task automatic test_random();
        int lat; bit tail; bit got; bit exp_p;
        int r, k, x, y, px, py; bit pv;
        logic [63:0] v;
        logic [7:0]  b, prev;
        for (int f = 0; f < 8; f++) begin
            prev = 8'h11;
            for (int e = 0; e < 8; e++) begin
                r = int'($urandom_range(0, 9));
                case (r)
                    0: b = {4'($urandom_range(0, 15)), 4'h0};
                    1: b = {4'h0, 4'($urandom_range(0, 15))};
                    2: b = prev;
                    default: b = {4'($urandom_range(1, 15)), 4'($urandom_range(1, 15))};
                endcase
                v[e*8 +: 8] = b;
                prev = b;
            end
            model_load(v);
            do_frame(v, lat, tail);
            checks++; if (lat !== 10) begin errors++; $display("FAIL rand_latency frame=%0d got=%0d want=10", f, lat); end
            checks++; if (cell_count !== 4'(model_count)) begin errors++; $display("FAIL rand_count frame=%0d got=%0d want=%0d", f, cell_count, model_count); end
            checks++; if (overlap_err !== (OVL_EN & model_ovl)) begin errors++; $display("FAIL rand_overlap frame=%0d got=%b want=%b", f, overlap_err, OVL_EN & model_ovl); end
            for (int p = 0; p < 12; p++) begin
                k = int'($urandom_range(0, 7));
                x = int'(v[k*8 +: 4]);
                y = int'(v[k*8+4 +: 4]);
                if (p % 2 == 0 && x >= 1 && y >= 1) begin
                    px = 80 + (x - 1) * 32 + int'($urandom_range(0, 31));
                    py = (y - 1) * 32 + int'($urandom_range(0, 31));
                end else begin
                    px = int'($urandom_range(0, 639));
                    py = int'($urandom_range(0, 499));
                end
                pv = ($urandom_range(0, 7) != 0);
                exp_p = ref_pix(px, py, pv);
                probe(px, py, pv, got);
                checks++; if (got !== exp_p) begin errors++; $display("FAIL rand_pixel frame=%0d (%0d,%0d,v=%b) got=%b want=%b", f, px, py, pv, got, exp_p); end
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        test_reset();
        test_single();
        test_corner();
        test_overlap();
        test_stability();
        test_reset_mid();
        test_pixel_valid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
